// File: rtl/control_types_pkg.sv
// Shared control-path types and the LSU lane/alignment helpers.
package control_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    // Memory operation issued by the control path to the MEM stage.
    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_op_t;

    // Load/store unit handshake state.
    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    function automatic logic is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
        logic m;
        m = 1'b0;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: m = a[0];
            MEM_LW, MEM_SW:          m = (a != 2'b00);
            default:                 m = 1'b0;
        endcase
        return m;
    endfunction

    // Byte enables by access size; loads and stores share the pattern.
    function automatic logic [BE_W-1:0] lane_be(input mem_op_t op, input logic [1:0] a);
        logic [BE_W-1:0] be;
        be = '0;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: be = 4'b0001 << a;
            MEM_LH, MEM_LHU, MEM_SH: be = a[1] ? 4'b1100 : 4'b0011;
            MEM_LW, MEM_SW:          be = 4'b1111;
            default:                 be = '0;
        endcase
        return be;
    endfunction

    // Replicate narrow store data so every lane carries it; be picks the lane.
    function automatic logic [WORD_W-1:0] lane_wdata(input mem_op_t op, input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] d;
        d = w;
        case (op)
            MEM_SB:  d = {4{w[7:0]}};
            MEM_SH:  d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Shifts the addressed lane of a read word down to bit 0 and extends it.
module lsu_load_align
    import control_types_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  mem_op_t         i_mem_op,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_word,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_word >> {i_addr_lo, 3'b000};

    // Size/sign selection on the lane-aligned word.
    always_comb begin
        o_result = w_shifted;
        case (i_mem_op)
            MEM_LB:  o_result = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            MEM_LBU: o_result = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            MEM_LH:  o_result = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            MEM_LHU: o_result = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: o_result = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory access with a
// variable-latency ack, stalling the pipeline until the access finishes.
// Only XLEN = 32 is supported.
module mem_stage_lsu
    import control_types_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  mem_op_t         mem_op_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            misalign_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i
);

    lsu_state_t      r_state;
    mem_op_t         r_op;
    logic [XLEN-1:0] r_addr;
    logic [3:0]      r_be;
    logic            r_we;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;

    logic            w_misalign;
    logic            w_active;
    logic            w_in_req;
    logic [XLEN-1:0] w_load_data;

    assign w_misalign = valid_i && is_misaligned(mem_op_i, addr_i[1:0]);
    assign w_active   = valid_i && (mem_op_i != MEM_NOP) && !w_misalign;
    assign w_in_req   = (r_state == LSU_REQ);

    // Extraction always uses the captured op/address, never the live inputs.
    lsu_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_mem_op  (r_op),
        .i_addr_lo (r_addr[1:0]),
        .i_word    (dmem_rdata_i),
        .o_result  (w_load_data)
    );

    // Access FSM; captures the request on acceptance and the load result on ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LSU_IDLE;
            r_op    <= MEM_NOP;
            r_addr  <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_active) begin
                        r_state <= LSU_REQ;
                        r_op    <= mem_op_i;
                        r_addr  <= addr_i;
                        r_be    <= lane_be(mem_op_i, addr_i[1:0]);
                        r_we    <= is_store(mem_op_i);
                        r_wdata <= lane_wdata(mem_op_i, wdata_i);
                    end
                end
                LSU_REQ: begin
                    if (dmem_ack_i) begin
                        r_state <= LSU_DONE;
                        if (is_load(r_op)) begin
                            r_rdata <= w_load_data;
                        end
                    end
                end
                LSU_DONE: begin
                    r_state <= LSU_IDLE;
                end
                default: begin
                    r_state <= LSU_IDLE;
                end
            endcase
        end
    end

    // Memory-side outputs come only from captured state, so they hold until ack.
    assign dmem_req_o   = w_in_req;
    assign dmem_we_o    = w_in_req && r_we;
    assign dmem_be_o    = w_in_req ? r_be : 4'b0000;
    assign dmem_addr_o  = {r_addr[XLEN-1:2], 2'b00};
    assign dmem_wdata_o = r_wdata;

    // Pipeline-side outputs; the stall releases in DONE so the next op can enter.
    assign done_o     = (r_state == LSU_DONE);
    assign stall_o    = w_active && (r_state != LSU_DONE);
    assign misalign_o = w_misalign;
    assign rdata_o    = r_rdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with hand-computed expected values.
module tb_mem_stage_lsu;
    import control_types_pkg::*;

    logic        clk;
    logic        rst;
    logic        valid_i;
    mem_op_t     mem_op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu #(
        .XLEN (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_op_i     (mem_op_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .misalign_o   (misalign_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        valid_i      = 1'b0;
        mem_op_i     = MEM_NOP;
        addr_i       = '0;
        wdata_i      = '0;
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = '0;
        tick();
        tick();
        #1;
        check("rst_req",   32'(dmem_req_o), 32'd0);
        check("rst_we",    32'(dmem_we_o),  32'd0);
        check("rst_be",    32'(dmem_be_o),  32'd0);
        check("rst_done",  32'(done_o),     32'd0);
        check("rst_rdata", rdata_o,         32'd0);
        check("rst_stall", 32'(stall_o),    32'd0);
        check("rst_mis",   32'(misalign_o), 32'd0);
        rst = 1'b0;
        tick();

        // SW with same-cycle ack
        valid_i = 1'b1; mem_op_i = MEM_SW; addr_i = 32'h100; wdata_i = 32'hDEADBEEF;
        #1;
        check("sw_acc_stall", 32'(stall_o),    32'd1);
        check("sw_acc_req",   32'(dmem_req_o), 32'd0);
        tick();
        dmem_ack_i = 1'b1;
        #1;
        check("sw_req",   32'(dmem_req_o), 32'd1);
        check("sw_we",    32'(dmem_we_o),  32'd1);
        check("sw_addr",  dmem_addr_o,     32'h100);
        check("sw_be",    32'(dmem_be_o),  32'hF);
        check("sw_wdata", dmem_wdata_o,    32'hDEADBEEF);
        check("sw_stall", 32'(stall_o),    32'd1);
        check("sw_done0", 32'(done_o),     32'd0);
        tick();
        dmem_ack_i = 1'b0;
        #1;
        check("sw_done",   32'(done_o),     32'd1);
        check("sw_stall3", 32'(stall_o),    32'd0);
        check("sw_req3",   32'(dmem_req_o), 32'd0);
        valid_i = 1'b0;
        tick();
        check("sw_idle_done", 32'(done_o), 32'd0);

        // SB to the top byte lane
        valid_i = 1'b1; mem_op_i = MEM_SB; addr_i = 32'h103; wdata_i = 32'h000000A5;
        tick();
        #1;
        check("sb_be",    32'(dmem_be_o), 32'h8);
        check("sb_wdata", dmem_wdata_o,   32'hA5A5A5A5);
        check("sb_addr",  dmem_addr_o,    32'h100);
        check("sb_we",    32'(dmem_we_o), 32'd1);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0; valid_i = 1'b0;
        #1;
        check("sb_done", 32'(done_o), 32'd1);
        tick();

        // LB with a 3-cycle ack delay; upstream inputs change while waiting
        valid_i = 1'b1; mem_op_i = MEM_LB; addr_i = 32'h102; dmem_rdata_i = 32'hFFFFFFFF;
        tick();
        valid_i = 1'b0; mem_op_i = MEM_NOP; addr_i = 32'hABC;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("lb_wait_req",  32'(dmem_req_o), 32'd1);
            check("lb_wait_addr", dmem_addr_o,     32'h100);
            check("lb_wait_be",   32'(dmem_be_o),  32'h4);
            check("lb_wait_we",   32'(dmem_we_o),  32'd0);
            tick();
        end
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12803456;
        #1;
        check("lb_req4", 32'(dmem_req_o), 32'd1);
        check("lb_be4",  32'(dmem_be_o),  32'h4);
        tick();
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'hFFFFFFFF;
        #1;
        check("lb_done",  32'(done_o), 32'd1);
        check("lb_rdata", rdata_o,     32'hFFFFFF80);
        tick();

        // LBU, same stimulus
        valid_i = 1'b1; mem_op_i = MEM_LBU; addr_i = 32'h102;
        tick();
        valid_i = 1'b0;
        #1;
        check("lbu_hold_rdata", rdata_o, 32'hFFFFFF80);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12803456;
        tick();
        dmem_ack_i = 1'b0;
        #1;
        check("lbu_done",  32'(done_o), 32'd1);
        check("lbu_rdata", rdata_o,     32'h00000080);
        tick();

        // Misalignment detection
        valid_i = 1'b1; mem_op_i = MEM_LW; addr_i = 32'h106;
        #1;
        check("lw_mis",       32'(misalign_o), 32'd1);
        check("lw_mis_stall", 32'(stall_o),    32'd0);
        check("lw_mis_req",   32'(dmem_req_o), 32'd0);
        tick();
        check("lw_mis_noreq", 32'(dmem_req_o), 32'd0);
        check("lw_mis_nodone", 32'(done_o),    32'd0);
        mem_op_i = MEM_SH; addr_i = 32'h201;
        #1;
        check("sh_mis", 32'(misalign_o), 32'd1);
        mem_op_i = MEM_LHU; addr_i = 32'h203;
        #1;
        check("lhu_mis", 32'(misalign_o), 32'd1);
        mem_op_i = MEM_SW; addr_i = 32'h102;
        #1;
        check("sw_mis", 32'(misalign_o), 32'd1);
        mem_op_i = MEM_LB; addr_i = 32'h203;
        #1;
        check("lb_nomis",   32'(misalign_o), 32'd0);
        check("lb_nomis_st", 32'(stall_o),   32'd1);
        valid_i = 1'b0;
        tick();

        // Reset while a request is outstanding
        valid_i = 1'b1; mem_op_i = MEM_LW; addr_i = 32'h300;
        tick();
        #1;
        check("rq_req", 32'(dmem_req_o), 32'd1);
        rst = 1'b1; valid_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rq_req0",  32'(dmem_req_o), 32'd0);
        check("rq_done0", 32'(done_o),     32'd0);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h55555555;
        tick();
        #1;
        check("rq_late_done",  32'(done_o),     32'd0);
        check("rq_late_req",   32'(dmem_req_o), 32'd0);
        check("rq_late_rdata", rdata_o,         32'd0);
        dmem_ack_i = 1'b0;
        tick();
        check("rq_late_done2", 32'(done_o), 32'd0);

        // Back-to-back LH then SH
        valid_i = 1'b1; mem_op_i = MEM_LH; addr_i = 32'h202; wdata_i = 32'd0;
        tick();
        #1;
        check("lh_be", 32'(dmem_be_o), 32'hC);
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hBEEF0000;
        tick();
        dmem_ack_i = 1'b0; mem_op_i = MEM_SH; addr_i = 32'h200; wdata_i = 32'h00001234;
        #1;
        check("lh_done",  32'(done_o),     32'd1);
        check("lh_rdata", rdata_o,         32'hFFFFBEEF);
        check("lh_stall", 32'(stall_o),    32'd0);
        check("lh_req",   32'(dmem_req_o), 32'd0);
        tick();
        check("sh_acc_stall", 32'(stall_o),    32'd1);
        check("sh_acc_req",   32'(dmem_req_o), 32'd0);
        check("sh_acc_done",  32'(done_o),     32'd0);
        tick();
        check("sh_req",   32'(dmem_req_o), 32'd1);
        check("sh_be",    32'(dmem_be_o),  32'h3);
        check("sh_wdata", dmem_wdata_o,    32'h12341234);
        check("sh_addr",  dmem_addr_o,     32'h200);
        check("sh_we",    32'(dmem_we_o),  32'd1);
        dmem_ack_i = 1'b1;
        tick();
        dmem_ack_i = 1'b0; valid_i = 1'b0;
        #1;
        check("sh_done",       32'(done_o), 32'd1);
        check("sh_keep_rdata", rdata_o,     32'hFFFFBEEF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
